// File: rtl/c5_gpio.sv
// c5_gpio: memory-mapped GPIO, LED and cycle-counter peripheral with programmable
// wait states, a three-flop input synchroniser, rising-edge capture and a level interrupt.
module c5_gpio #(
    parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic [29:0] I_address,
    input  logic [3:0]  I_byte_we,
    input  logic [31:0] I_data_w,
    output logic [31:0] O_data_r,
    output logic        O_pause,
    input  logic [31:0] I_gpio_in,
    output logic [31:0] O_gpio_out,
    output logic [31:0] O_gpio_oe,
    output logic        O_led,
    output logic        O_intr
);
    localparam logic [3:0] WAIT_N = 4'(WAIT_CYCLES);

    typedef enum logic [2:0] {
        REG_OUT    = 3'd0,
        REG_OE     = 3'd1,
        REG_IN     = 3'd2,
        REG_EDGE   = 3'd3,
        REG_IRQ_EN = 3'd4,
        REG_LED    = 3'd5,
        REG_CYCLE  = 3'd6,
        REG_RSVD   = 3'd7
    } reg_sel_e;

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [31:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    reg_sel_e    sel;
    logic        hit, done, wr_en, rd_en;
    logic [3:0]  cnt;
    logic [31:0] wmask, clr, rise, rdata;
    logic [31:0] out_q, oe_q, edge_q, irq_en_q, cycle_q;
    logic        led_q;
    logic [31:0] sync_p1, sync_p2, sync_p3;

    assign sel   = reg_sel_e'(I_address[2:0]);
    assign hit   = (I_address[29:3] == BASE_ADDR[31:5]);
    assign done  = hit && (cnt == WAIT_N);
    assign wr_en = done && (I_byte_we != 4'b0000);
    assign rd_en = done && (I_byte_we == 4'b0000);
    assign wmask = lane_mask(I_byte_we);
    // A W1C write only clears the lanes it enables; a same-cycle rise still wins.
    assign clr   = (wr_en && sel == REG_EDGE) ? (I_data_w & wmask) : 32'h0;
    assign rise  = sync_p2 & ~sync_p3;

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            cnt      <= 4'd0;
            out_q    <= 32'h0;
            oe_q     <= 32'h0;
            edge_q   <= 32'h0;
            irq_en_q <= 32'h0;
            led_q    <= 1'b0;
            cycle_q  <= 32'h0;
            sync_p1  <= 32'h0;
            sync_p2  <= 32'h0;
            sync_p3  <= 32'h0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            // synchroniser stages p1 -> p2 -> p3
            sync_p1 <= I_gpio_in;
            sync_p2 <= sync_p1;
            sync_p3 <= sync_p2;
            edge_q  <= (edge_q & ~clr) | rise;

            if (!hit || done) cnt <= 4'd0;
            else              cnt <= cnt + 4'd1;

            if (wr_en) begin
                unique case (sel)
                    REG_OUT:    out_q    <= merge_lanes(out_q, I_data_w, wmask);
                    REG_OE:     oe_q     <= merge_lanes(oe_q, I_data_w, wmask);
                    REG_IRQ_EN: irq_en_q <= merge_lanes(irq_en_q, I_data_w, wmask);
                    REG_LED:    if (I_byte_we[0]) led_q <= I_data_w[0];
                    default:    ;
                endcase
            end
        end
    end

    always_comb begin
        rdata = 32'h0;
        unique case (sel)
            REG_OUT:    rdata = out_q;
            REG_OE:     rdata = oe_q;
            REG_IN:     rdata = sync_p2;
            REG_EDGE:   rdata = edge_q;
            REG_IRQ_EN: rdata = irq_en_q;
            REG_LED:    rdata = {31'b0, led_q};
            REG_CYCLE:  rdata = cycle_q;
            default:    rdata = 32'h0;
        endcase
    end

    assign O_data_r   = rd_en ? rdata : 32'h0;
    assign O_pause    = hit && (cnt != WAIT_N) && !I_rst;
    assign O_gpio_out = out_q;
    assign O_gpio_oe  = oe_q;
    assign O_led      = led_q;
    assign O_intr     = |(edge_q & irq_en_q);
endmodule
